gpio_config_serializer: RTL and testbench

Hardware loader that shifts the per-pad 13-bit GPIO configuration words into the two user-area GPIO configuration chains (user 1 = GPIO 0–18, user 2 = GPIO 37–19) and strobes the load, so firmware or SPI writes a single "serial transfer" bit instead of bit-banging every clock. Sits in housekeeping between the GPIO configuration register file (upstream, read port) and the serial_clock/serial_resetn/serial_load/serial_data_1/serial_data_2 mux that also carries the bit-bang path (downstream). Produces the same waveform the bit-bang sequence produces: MSB-first, farthest pad first, then one load pulse.

---
 rtl/gpio_config_serializer.sv | 153 +++++++++++++++
 tb/tb_gpio_config_serializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_config_serializer.sv
// rtl/gpio_config_serializer.sv - Shifts per-pad GPIO config words into both user-area chains and strobes the load
module gpio_config_serializer #(
    parameter int NUM_IO    = 19,
    parameter int CFG_WIDTH = 13,
    parameter int CLK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 xfer_start,
    output logic                 xfer_busy,
    output logic                 xfer_done,
    output logic [5:0]           cfg_addr1,
    output logic [5:0]           cfg_addr2,
    input  logic [CFG_WIDTH-1:0] cfg_data1,
    input  logic [CFG_WIDTH-1:0] cfg_data2,
    output logic                 serial_clock,
    output logic                 serial_resetn,
    output logic                 serial_load,
    output logic                 serial_data_1,
    output logic                 serial_data_2
);
    localparam int CW = (CLK_DIV > 0) ? $clog2(2 * CLK_DIV) : 1;
    localparam int KW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam int BW = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;

    localparam logic [CW-1:0] PHASE_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PAIR_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [KW-1:0] K_LAST     = KW'(NUM_IO - 1);
    localparam logic [BW-1:0] B_MSB      = BW'(CFG_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, CLR, FETCH, SHIFT, LOAD} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [KW-1:0]        k;
    logic [BW-1:0]        b;
    logic                 high_phase;
    logic [CFG_WIDTH-1:0] shreg1;
    logic [CFG_WIDTH-1:0] shreg2;

    // Chain 1 is fed from its far end (GPIO NUM_IO-1) down to GPIO 0; chain 2 from GPIO NUM_IO upward.
    function automatic logic [5:0] addr1_of(input logic [KW-1:0] idx);
        return 6'(NUM_IO - 1 - int'(idx));
    endfunction

    function automatic logic [5:0] addr2_of(input logic [KW-1:0] idx);
        return 6'(NUM_IO + int'(idx));
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cnt           <= '0;
            k             <= '0;
            b             <= '0;
            high_phase    <= 1'b0;
            shreg1        <= '0;
            shreg2        <= '0;
            xfer_busy     <= 1'b0;
            xfer_done     <= 1'b0;
            cfg_addr1     <= '0;
            cfg_addr2     <= '0;
            serial_clock  <= 1'b0;
            serial_resetn <= 1'b0;
            serial_load   <= 1'b0;
            serial_data_1 <= 1'b0;
            serial_data_2 <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            case (state)
                IDLE: begin
                    serial_resetn <= 1'b1;
                    if (xfer_start) begin
                        state         <= CLR;
                        xfer_busy     <= 1'b1;
                        serial_resetn <= 1'b0;
                        cnt           <= '0;
                        k             <= '0;
                    end
                end

                CLR: begin
                    if (cnt == PAIR_LAST) begin
                        state         <= FETCH;
                        serial_resetn <= 1'b1;
                        cnt           <= '0;
                        cfg_addr1     <= addr1_of(k);
                        cfg_addr2     <= addr2_of(k);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FETCH: begin
                    // The register file answers combinationally, so the word is valid this cycle.
                    shreg1        <= cfg_data1;
                    shreg2        <= cfg_data2;
                    serial_data_1 <= cfg_data1[CFG_WIDTH-1];
                    serial_data_2 <= cfg_data2[CFG_WIDTH-1];
                    b             <= B_MSB;
                    high_phase    <= 1'b0;
                    cnt           <= '0;
                    state         <= SHIFT;
                end

                SHIFT: begin
                    if (cnt != PHASE_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!high_phase) begin
                            high_phase   <= 1'b1;
                            serial_clock <= 1'b1;
                        end else begin
                            high_phase   <= 1'b0;
                            serial_clock <= 1'b0;
                            if (b != '0) begin
                                // Next bit goes out on the same edge the clock falls.
                                b             <= b - 1'b1;
                                serial_data_1 <= shreg1[b - 1'b1];
                                serial_data_2 <= shreg2[b - 1'b1];
                            end else if (k != K_LAST) begin
                                k         <= k + 1'b1;
                                cfg_addr1 <= addr1_of(k + 1'b1);
                                cfg_addr2 <= addr2_of(k + 1'b1);
                                state     <= FETCH;
                            end else begin
                                state       <= LOAD;
                                serial_load <= 1'b1;
                            end
                        end
                    end
                end

                LOAD: begin
                    if (cnt == PAIR_LAST) begin
                        state     <= IDLE;
                        xfer_busy <= 1'b0;
                        xfer_done <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        if (cnt == PHASE_LAST) begin
                            serial_load <= 1'b0;
                        end
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_config_serializer.sv
// tb/tb_gpio_config_serializer.sv - Randomized self-checking bench for gpio_config_serializer
module tb_gpio_config_serializer;
    localparam int NUM_IO     = 19;
    localparam int CFG_WIDTH  = 13;
    localparam int CLK_DIV    = 2;
    localparam int NBITS      = NUM_IO * CFG_WIDTH;
    localparam int BUSY_LEN   = 2 * CLK_DIV + NUM_IO * (1 + 2 * CLK_DIV * CFG_WIDTH) + 2 * CLK_DIV;
    localparam int BUSY_LEN_B = 2 + NUM_IO * (1 + 2 * CFG_WIDTH) + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, xfer_start, start_b;
    logic [12:0] cfg_mem [0:63];

    logic        xfer_busy, xfer_done, sclk, srstn, sload, sd1, sd2;
    logic [5:0]  cfg_addr1, cfg_addr2;
    logic [12:0] cfg_data1, cfg_data2;

    logic        busy_b, done_b, sclk_b, srstn_b, sload_b, sd1_b, sd2_b;
    logic [5:0]  addr1_b, addr2_b;
    logic [12:0] data1_b, data2_b;

    assign cfg_data1 = cfg_mem[cfg_addr1];
    assign cfg_data2 = cfg_mem[cfg_addr2];
    assign data1_b   = cfg_mem[addr1_b];
    assign data2_b   = cfg_mem[addr2_b];

    gpio_config_serializer #(.NUM_IO(NUM_IO), .CFG_WIDTH(CFG_WIDTH), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .resetn(resetn), .xfer_start(xfer_start),
        .xfer_busy(xfer_busy), .xfer_done(xfer_done),
        .cfg_addr1(cfg_addr1), .cfg_addr2(cfg_addr2),
        .cfg_data1(cfg_data1), .cfg_data2(cfg_data2),
        .serial_clock(sclk), .serial_resetn(srstn), .serial_load(sload),
        .serial_data_1(sd1), .serial_data_2(sd2)
    );

    gpio_config_serializer #(.NUM_IO(NUM_IO), .CFG_WIDTH(CFG_WIDTH), .CLK_DIV(1)) dut_b (
        .clk(clk), .resetn(resetn), .xfer_start(start_b),
        .xfer_busy(busy_b), .xfer_done(done_b),
        .cfg_addr1(addr1_b), .cfg_addr2(addr2_b),
        .cfg_data1(data1_b), .cfg_data2(data2_b),
        .serial_clock(sclk_b), .serial_resetn(srstn_b), .serial_load(sload_b),
        .serial_data_1(sd1_b), .serial_data_2(sd2_b)
    );

    // Observer: models the two physical chains and records waveform facts.
    logic        bitq1 [$];
    logic        bitq2 [$];
    int          busy_lens [$];
    int          addrq1 [$];
    int          addrq2 [$];
    logic [12:0] latch [0:37];
    int busy_run = 0, rises_x = 0, stable = 0, viol = 0;
    int loads = 0, dones = 0, load_w = 0, last_load_w = 0, base = 0;
    logic p_sclk = 0, p_sd1 = 0, p_sd2 = 0, p_load = 0;
    logic [12:0] w1, w2;

    always @(negedge clk) begin
        if (xfer_busy) busy_run++;
        else if (busy_run != 0) begin
            busy_lens.push_back(busy_run);
            busy_run = 0;
        end
        if (xfer_done) dones++;
        if (sd1 !== p_sd1 || sd2 !== p_sd2) begin
            if (sclk) viol++;
            stable = 0;
        end else begin
            stable++;
        end
        if (sclk && !p_sclk) begin
            if (stable < CLK_DIV) viol++;
            if (rises_x % CFG_WIDTH == 0) begin
                addrq1.push_back(int'(cfg_addr1));
                addrq2.push_back(int'(cfg_addr2));
            end
            rises_x++;
            bitq1.push_back(sd1);
            bitq2.push_back(sd2);
        end
        if (!xfer_busy) rises_x = 0;
        if (sload) load_w++;
        if (sload && !p_load) begin
            loads++;
            // First word shifted ends up at the far pad of each chain.
            base = bitq1.size() - NBITS;
            if (base >= 0) begin
                for (int j = 0; j < NUM_IO; j++) begin
                    w1 = '0;
                    w2 = '0;
                    for (int i = 0; i < CFG_WIDTH; i++) begin
                        w1 = {w1[11:0], bitq1[base + j * CFG_WIDTH + i]};
                        w2 = {w2[11:0], bitq2[base + j * CFG_WIDTH + i]};
                    end
                    latch[NUM_IO - 1 - j] = w1;
                    latch[NUM_IO + j]     = w2;
                end
            end
        end
        if (!sload && p_load) begin
            last_load_w = load_w;
            load_w = 0;
        end
        p_sclk = sclk;
        p_sd1  = sd1;
        p_sd2  = sd2;
        p_load = sload;
    end

    int   run_b = 0, rises_b = 0, viol_b = 0;
    int   lens_b [$];
    logic pb_sclk = 0, pb_sd1 = 0, pb_sd2 = 0;

    always @(negedge clk) begin
        if (busy_b) run_b++;
        else if (run_b != 0) begin
            lens_b.push_back(run_b);
            run_b = 0;
        end
        if (sclk_b && !pb_sclk) rises_b++;
        if ((sd1_b !== pb_sd1 || sd2_b !== pb_sd2) && sclk_b) viol_b++;
        pb_sclk = sclk_b;
        pb_sd1  = sd1_b;
        pb_sd2  = sd2_b;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  xfer_busy, 0);
        check({tag, "_done"},  xfer_done, 0);
        check({tag, "_addr1"}, cfg_addr1, 0);
        check({tag, "_addr2"}, cfg_addr2, 0);
        check({tag, "_sclk"},  sclk, 0);
        check({tag, "_srstn"}, srstn, 0);
        check({tag, "_load"},  sload, 0);
        check({tag, "_sd1"},   sd1, 0);
        check({tag, "_sd2"},   sd2, 0);
    endtask

    task automatic randomize_cfg();
        for (int p = 0; p < 2 * NUM_IO; p++) cfg_mem[p] = 13'($urandom);
    endtask

    task automatic do_xfer(input string tag, input int poke_at, input bit on_done);
        int  nb, nl, nd, nbz, na, nv, bad;
        bit  got;
        nb = bitq1.size(); nl = loads; nd = dones; nbz = busy_lens.size();
        na = addrq1.size(); nv = viol;
        if (on_done) check({tag, "_start_on_done"}, xfer_done, 1);
        else         check({tag, "_idle_before"}, xfer_busy, 0);
        xfer_start = 1'b1;
        step();
        xfer_start = 1'b0;
        check({tag, "_busy_rise"}, xfer_busy, 1);
        got = 1'b0;
        for (int cyc = 1; cyc < 3000 && !got; cyc++) begin
            xfer_start = (cyc == poke_at);
            step();
            if (xfer_done) got = 1'b1;
        end
        xfer_start = 1'b0;
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_busy_runs"}, busy_lens.size() - nbz, 1);
        check({tag, "_busy_len"}, (busy_lens.size() > nbz) ? busy_lens[nbz] : 0, BUSY_LEN);
        check({tag, "_loads"}, loads - nl, 1);
        check({tag, "_load_width"}, last_load_w, CLK_DIV);
        check({tag, "_dones"}, dones - nd, 1);
        check({tag, "_rises"}, bitq1.size() - nb, NBITS);
        if (bitq1.size() > nb) begin
            check({tag, "_first_bit1"}, bitq1[nb], cfg_mem[NUM_IO - 1][CFG_WIDTH - 1]);
            check({tag, "_first_bit2"}, bitq2[nb], cfg_mem[NUM_IO][CFG_WIDTH - 1]);
        end
        check({tag, "_fetches"}, addrq1.size() - na, NUM_IO);
        bad = 0;
        for (int j = 0; j < NUM_IO; j++) begin
            if (na + j >= addrq1.size()) bad++;
            else if (addrq1[na + j] != NUM_IO - 1 - j || addrq2[na + j] != NUM_IO + j) bad++;
        end
        check({tag, "_addr_order_bad"}, bad, 0);
        for (int p = 0; p < 2 * NUM_IO; p++)
            check($sformatf("%s_pad%0d", tag, p), latch[p], cfg_mem[p]);
        check({tag, "_data_timing_viol"}, viol - nv, 0);
    endtask

    logic [12:0] saved [0:37];
    int          nl_abort, bad_abort, nbz_b, rb, vb;
    bit          got_b;

    initial begin
        resetn = 1'b0; xfer_start = 1'b0; start_b = 1'b0;
        for (int p = 0; p < 64; p++)
            cfg_mem[p] = (p == 0 || p == 37) ? 13'h1809 : 13'h0403;
        for (int p = 0; p < 38; p++) latch[p] = '0;
        for (int i = 0; i < 6; i++) begin
            xfer_start = 1'($urandom_range(0, 1));
            step();
        end
        xfer_start = 1'b0;
        check_quiet("reset");
        check("reset_busy_b", busy_b, 0);
        resetn = 1'b1;
        step();
        check("post_reset_srstn", srstn, 1);
        check("post_reset_busy", xfer_busy, 0);
        check("post_reset_srstn_b", srstn_b, 1);
        repeat (3) step();
        check("idle_busy", xfer_busy, 0);

        do_xfer("fixed", 0, 0);

        randomize_cfg();
        step();
        do_xfer("poke500", 500, 0);

        randomize_cfg();
        do_xfer("back2back", 0, 1);

        for (int p = 0; p < 38; p++) saved[p] = latch[p];
        nl_abort = loads;
        randomize_cfg();
        step();
        xfer_start = 1'b1;
        step();
        xfer_start = 1'b0;
        repeat (299) step();
        check("abort_busy_before", xfer_busy, 1);
        resetn = 1'b0;
        #1;
        check_quiet("abort");
        repeat (3) step();
        check("abort_no_load", loads - nl_abort, 0);
        bad_abort = 0;
        for (int p = 0; p < 38; p++) if (latch[p] !== saved[p]) bad_abort++;
        check("abort_latch_kept_bad", bad_abort, 0);
        resetn = 1'b1;
        repeat (2) step();
        do_xfer("after_abort", 0, 0);

        nbz_b = lens_b.size(); rb = rises_b; vb = viol_b;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        check("div1_busy_rise", busy_b, 1);
        got_b = 1'b0;
        for (int cyc = 0; cyc < 2000 && !got_b; cyc++) begin
            step();
            if (done_b) got_b = 1'b1;
        end
        check("div1_done_seen", got_b, 1);
        check("div1_busy_len", (lens_b.size() > nbz_b) ? lens_b[nbz_b] : 0, BUSY_LEN_B);
        check("div1_rises", rises_b - rb, NBITS);
        check("div1_data_timing_viol", viol_b - vb, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
